// File: rtl/fwd_sel_unit.sv
// fwd_sel_unit: operand-forwarding selects and load-use stall for a 5-stage pipeline
module fwd_sel_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);
  logic             r_ex_v, r_ex_rw, r_ex_mr, r_mem_v, r_mem_rw, r_wb_v, r_wb_rw;
  logic [REG_W-1:0] r_ex_rs, r_ex_rt, r_ex_rd, r_mem_rd, r_wb_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_kill;
  function automatic logic [1:0] f_sel(input logic [REG_W-1:0] src);
    return !r_ex_v ? 2'd0 :
           src == '0 ? 2'd3 :
           (r_mem_v && r_mem_rw && r_mem_rd == src) ? 2'd1 :
           (r_wb_v && r_wb_rw && r_wb_rd == src) ? 2'd2 : 2'd0;
  endfunction
  assign stall = id_valid & r_ex_v & r_ex_mr & r_ex_rw & (r_ex_rd != '0)
               & (r_ex_rd == id_rs | r_ex_rd == id_rt);
  assign w_kill = flush | stall;
  assign sel_a = f_sel(r_ex_rs);
  assign sel_b = f_sel(r_ex_rt);
  assign stall_count = r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_v  <= 1'b0;
      r_ex_rw <= 1'b0;
      r_ex_mr <= 1'b0;
      r_mem_v <= 1'b0;
      r_wb_v  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_wb_v   <= r_mem_v;
      r_wb_rw  <= r_mem_rw;
      r_wb_rd  <= r_mem_rd;
      r_mem_v  <= r_ex_v;
      r_mem_rw <= r_ex_rw;
      r_mem_rd <= r_ex_rd;
      r_ex_v   <= id_valid & ~w_kill;
      r_ex_rw  <= id_regwrite & ~w_kill;
      r_ex_mr  <= id_memread & ~w_kill;
      r_ex_rs  <= id_rs;
      r_ex_rt  <= id_rt;
      r_ex_rd  <= id_rd;
      if (stall && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule
